// File: rtl/ov7670_pkg.sv
// Types and timing defaults shared by the OV7670 DVP capture and stream-generator blocks.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  localparam int DEF_H_ACTIVE    = 320;
  localparam int DEF_V_ACTIVE    = 240;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_ADDR_W      = 17;

  // RGB444 goes out as {pad,R} then {G,B}
  localparam logic [3:0] HI_PAD = 4'h0;

  function automatic logic [7:0] rgb444_hi(input logic [11:0] px);
    return {HI_PAD, px[11:8]};
  endfunction

  function automatic logic [7:0] rgb444_lo(input logic [11:0] px);
    return px[7:0];
  endfunction

endpackage

// File: rtl/ov7670_timing.sv
// Frame/line timing for the DVP stream generator: h/v counters, state, registered vsync/href.
// state     | meaning
// ST_IDLE   | outputs low, waiting for enable
// ST_VSYNC  | vsync high for VSYNC_LINES lines
// ST_VBACK  | blank lines before the first active line
// ST_ACTIVE | V_ACTIVE lines, href for 2*H_ACTIVE cycles then H_BLANK low
// ST_VFRONT | blank lines after the frame; frame_done on its last cycle
module ov7670_timing
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic pclk,
  input  logic resetn,
  input  logic enable,
  output logic vsync,
  output logic href,
  output logic frame_done,
  output logic frame_start,
  output logic px_first,
  output logic px_second,
  output logic to_idle
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int H_W      = $clog2(LINE_LEN + 1);
  localparam int M1       = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int M2       = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int V_MAX    = (M1 > M2) ? M1 : M2;
  localparam int V_W      = $clog2(V_MAX + 1);
  localparam logic [H_W-1:0] H_LAST  = H_W'(LINE_LEN - 1);
  localparam logic [H_W-1:0] H_HREF  = H_W'(2 * H_ACTIVE);
  localparam logic [V_W-1:0] VF_LAST = V_W'(V_FRONT - 1);

  state_t state, state_nxt, follow;
  logic [H_W-1:0] h_cnt, h_nxt;
  logic [V_W-1:0] v_cnt, v_nxt, v_last;
  logic href_nxt, done_nxt;

  always_comb begin
    v_last = '0;
    follow = ST_IDLE;
    case (state)
      ST_VSYNC:  begin v_last = V_W'(VSYNC_LINES - 1); follow = ST_VBACK;  end
      ST_VBACK:  begin v_last = V_W'(V_BACK - 1);      follow = ST_ACTIVE; end
      ST_ACTIVE: begin v_last = V_W'(V_ACTIVE - 1);    follow = ST_VFRONT; end
      ST_VFRONT: begin v_last = VF_LAST; follow = enable ? ST_VSYNC : ST_IDLE; end
      default: ;
    endcase
  end

  // counters are already zero whenever the FSM sits in IDLE
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    if (state == ST_IDLE) begin
      if (enable) state_nxt = ST_VSYNC;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == v_last) begin
        v_nxt     = '0;
        state_nxt = follow;
      end else begin
        v_nxt = v_cnt + 1'b1;
      end
    end else begin
      h_nxt = h_cnt + 1'b1;
    end
  end

  assign href_nxt    = (state_nxt == ST_ACTIVE) && (h_nxt < H_HREF);
  assign done_nxt    = (state_nxt == ST_VFRONT) && (h_nxt == H_LAST) && (v_nxt == VF_LAST);
  assign px_first    = href_nxt && !h_nxt[0];
  assign px_second   = href_nxt && h_nxt[0];
  assign frame_start = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
  assign to_idle     = (state_nxt == ST_IDLE);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      vsync      <= (state_nxt == ST_VSYNC);
      href       <= href_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style DVP pixel source: replays RGB444 pixels from a latency-1 frame buffer
// as vsync/href/d bytes. Timing lives in ov7670_timing; this adds prefetch and byte mux.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        d,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic frame_start, px_first, px_second, to_idle;
  logic [11:0] pix;

  ov7670_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .pclk       (pclk),
    .resetn     (resetn),
    .enable     (enable),
    .vsync      (vsync),
    .href       (href),
    .frame_done (frame_done),
    .frame_start(frame_start),
    .px_first   (px_first),
    .px_second  (px_second),
    .to_idle    (to_idle)
  );

  // Address moves on as pixel p's first byte goes out, so the RAM has a full
  // two cycles to return pixel p+1 before its first byte.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      rd_addr <= '0;
      pix     <= '0;
      d       <= '0;
    end else begin
      if (frame_start || to_idle) begin
        rd_addr <= '0;
      end else if (px_first && (rd_addr != ADDR_LAST)) begin
        rd_addr <= rd_addr + 1'b1;
      end
      if (px_first) begin
        d   <= rgb444_hi(rd_data);
        pix <= rd_data;
      end else if (px_second) begin
        d <= rgb444_lo(pix);
      end else begin
        d <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: latency-1 RAM model, per-cycle frame reference model,
// randomized pixel data, enable glitches/drops and asynchronous resets mid-line.
module tb_ov7670_stream_gen;

  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 3;
  localparam int H_BLANK     = 2;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int ADDR_W      = 17;
  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int NPIX        = H_ACTIVE * V_ACTIVE;
  localparam int ACT_START   = (VSYNC_LINES + V_BACK) * LINE_LEN;
  localparam int ACT_LEN     = V_ACTIVE * LINE_LEN;
  localparam int FRAME_LEN   = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE_LEN;

  logic              pclk    = 1'b0;
  logic              resetn  = 1'b0;
  logic              enable  = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data = '0;
  logic              vsync, href, frame_done;
  logic [7:0]        d;
  logic [11:0]       mem [NPIX];

  int n_cmp = 0;
  int n_bad = 0;
  int prev_addr = 0;

  ov7670_stream_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT),
    .ADDR_W     (ADDR_W)
  ) dut (
    .pclk      (pclk),
    .resetn    (resetn),
    .enable    (enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .frame_done(frame_done)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk)
    rd_data <= (int'(rd_addr) < NPIX) ? mem[int'(rd_addr)] : 12'h000;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_href"}, href, 0);
    chk({tag, "_d"}, d, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Expected outputs at cycle k of a frame (k=0 is the first vsync cycle).
  task automatic check_cycle(input int k);
    int a, c, p, cur;
    logic e_hr;
    logic [7:0] e_d;
    e_hr = 1'b0;
    e_d  = 8'h00;
    a = k - ACT_START;
    if (a >= 0 && a < ACT_LEN) begin
      c = a % LINE_LEN;
      if (c < 2 * H_ACTIVE) begin
        e_hr = 1'b1;
        p    = (a / LINE_LEN) * H_ACTIVE + c / 2;
        e_d  = (c % 2 == 0) ? {4'h0, mem[p][11:8]} : mem[p][7:0];
      end
    end
    chk("vsync", vsync, (k < VSYNC_LINES * LINE_LEN) ? 1 : 0);
    chk("href", href, e_hr);
    chk("d", d, e_d);
    chk("frame_done", frame_done, (k == FRAME_LEN - 1) ? 1 : 0);

    cur = int'(rd_addr);
    if (k == 0) chk("addr_start", cur, 0);
    else chk("addr_step", ((cur == prev_addr) || (cur == prev_addr + 1)) ? 1 : 0, 1);
    a = k + 2 - ACT_START;
    if (a >= 0 && a < ACT_LEN && (a % LINE_LEN) < 2 * H_ACTIVE && (a % LINE_LEN) % 2 == 0)
      chk("prefetch", cur, (a / LINE_LEN) * H_ACTIVE + (a % LINE_LEN) / 2);
    if (k >= ACT_START + ACT_LEN) chk("addr_hold", cur, NPIX - 1);
    prev_addr = cur;
  endtask

  // mode 0: enable glitch mid-frame, 1: enable dropped in 2nd line, 2: async reset at ev_k
  task automatic run_frame(input int mode, input int ev_k, input bit directed);
    int n_href, n_done;
    n_href = 0;
    n_done = 0;
    if (!directed)
      for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (k > 0) @(negedge pclk);
      check_cycle(k);
      n_href += int'(href);
      n_done += int'(frame_done);
      if (directed && k == ACT_START)     chk("byte_r0", d, 8'h0A);
      if (directed && k == ACT_START + 1) chk("byte_gb0", d, 8'hBC);
      if (directed && k == ACT_START + 2) chk("byte_r1", d, 8'h01);
      if (directed && k == ACT_START + 3) chk("byte_gb1", d, 8'h01);
      if ((mode == 0 || mode == 1) && k == ev_k) enable = 1'b0;
      if (mode == 0 && k == ev_k + 3) enable = 1'b1;
      if (mode == 2 && k == ev_k) begin
        resetn = 1'b0;
        #1;
        check_idle("async_rst");
        repeat (2) begin
          @(negedge pclk);
          check_idle("in_rst");
        end
        resetn = 1'b1;
        return;
      end
    end
    chk("href_cycles", n_href, 2 * NPIX);
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    int mode, ev_k, n_idle;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'h100 + 12'(i);
    mem[0] = 12'hABC;

    resetn = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check_idle("reset");
    end
    resetn = 1'b1;
    @(negedge pclk);

    for (int it = 0; it < 10; it++) begin
      mode = (it == 0) ? 0 : (it % 3);
      if (mode == 2) ev_k = ACT_START + int'($urandom_range(0, ACT_LEN - 1));
      else ev_k = ACT_START + LINE_LEN + int'($urandom_range(0, LINE_LEN - 4));
      run_frame(mode, ev_k, it == 0);
      @(negedge pclk);
      if (mode == 1) begin
        n_idle = int'($urandom_range(2, 5));
        for (int i = 0; i < n_idle; i++) begin
          if (i > 0) @(negedge pclk);
          check_idle("idle");
        end
        enable = 1'b1;
        @(negedge pclk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
